// File: rtl/alu_share_ctrl.sv
// Round-robin sharer of one combinational ALU between two valid/ready requesters.
// Define ALU_SHARE_PERF_EN to add the perf_grant0/perf_grant1/perf_stall counters.
module alu_share_ctrl #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [WIDTH-1:0]  req_a0,
  input  logic [WIDTH-1:0]  req_a1,
  input  logic [WIDTH-1:0]  req_b0,
  input  logic [WIDTH-1:0]  req_b1,
  input  logic [CTRL_W-1:0] req_ctrl0,
  input  logic [CTRL_W-1:0] req_ctrl1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
`ifdef ALU_SHARE_PERF_EN
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1,
  output logic [31:0]       perf_stall,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_nxt;
  logic               rr_ptr;
  logic               owner;
  logic               grant_any;
  logic               grant_id;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [CTRL_W-1:0]  ctrl_q;

  // rr_ptr names the favoured requester when both are pending
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    grant_any = 1'b0;
    grant_id  = rr_ptr;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_any = 1'b1;
          grant_id  = (&req_valid) ? rr_ptr : req_valid[1];
          req_ready = grant_id ? 2'b10 : 2'b01;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = owner ? 2'b10 : 2'b01;
        if (rsp_ready[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      grant_any = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        owner  <= grant_id;
        rr_ptr <= ~grant_id;
        a_q    <= grant_id ? req_a1    : req_a0;
        b_q    <= grant_id ? req_b1    : req_b0;
        ctrl_q <= grant_id ? req_ctrl1 : req_ctrl0;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
      end
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = ctrl_q;
  assign busy     = (state != IDLE);

`ifdef ALU_SHARE_PERF_EN
  logic [1:0] stall_bits;
  assign stall_bits = req_valid & ~req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_stall  <= '0;
    end else begin
      if (grant_any && !grant_id) perf_grant0 <= perf_grant0 + 32'd1;
      if (grant_any &&  grant_id) perf_grant1 <= perf_grant1 + 32'd1;
      perf_stall <= perf_stall + {31'd0, stall_bits[0]} + {31'd0, stall_bits[1]};
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl with a small behavioural ALU attached.
// Perf counter checks are compiled only when ALU_SHARE_PERF_EN is defined.
module tb_alu_share_ctrl;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [WIDTH-1:0]  req_a0, req_a1, req_b0, req_b1;
  logic [CTRL_W-1:0] req_ctrl0, req_ctrl1;
  logic [WIDTH-1:0]  rsp_result, alu_a, alu_b, alu_result;
  logic              rsp_zero, alu_zero, busy;
  logic [CTRL_W-1:0] alu_ctrl;
`ifdef ALU_SHARE_PERF_EN
  logic [31:0]       perf_grant0, perf_grant1, perf_stall;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
`ifdef ALU_SHARE_PERF_EN
    .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall),
`endif
    .busy(busy)
  );

  // Behavioural shared ALU; unknown codes return a recognisable marker
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'hDEADBEEF;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    req_ctrl0 = '0; req_ctrl1 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_ready: got %b want 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp: got %h/%b want 0/0", rsp_result, rsp_zero); end
    checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 4'd0) begin errors++; $display("[TB] FAIL reset_alu: got %h %h %h want zeros", alu_a, alu_b, alu_ctrl); end
    tick();
    req_valid = 2'b00;
    reset = 1'b0;
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL idle_after_reset: busy=%b rdy=%b rsp=%b want 0/00/00", busy, req_ready, rsp_valid); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 2'b01; req_a0 = 32'd5; req_b0 = 32'd3; req_ctrl0 = 4'b0010;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL single_grant: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if (busy !== 1'b1 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL single_exec: busy=%b rdy=%b rsp=%b want 1/00/00", busy, req_ready, rsp_valid); end
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_ctrl !== 4'b0010) begin errors++; $display("[TB] FAIL single_alu_in: got %0d %0d %b want 5 3 0010", alu_a, alu_b, alu_ctrl); end
    tick();
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("[TB] FAIL single_rsp_valid: got %b want 01", rsp_valid); end
    checks++; if (rsp_result !== 32'd8 || rsp_zero !== 1'b0) begin errors++; $display("[TB] FAIL single_result: got %0d/%b want 8/0", rsp_result, rsp_zero); end
    rsp_ready = 2'b01;
    tick();
    #1;
    checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_done: rsp=%b busy=%b want 00/0", rsp_valid, busy); end
    rsp_ready = 2'b00;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_oh;
    logic [31:0] exp_res;
    do_reset();
    req_a0 = 32'h10; req_b0 = 32'd1; req_ctrl0 = 4'b0010;
    req_a1 = 32'h20; req_b1 = 32'd2; req_ctrl1 = 4'b0010;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_oh  = (k % 2 == 1) ? 2'b10 : 2'b01;
      exp_res = (k % 2 == 1) ? 32'h22 : 32'h11;
      #1;
      checks++; if (req_ready !== exp_oh) begin errors++; $display("[TB] FAIL rr_grant%0d: got %b want %b", k, req_ready, exp_oh); end
      tick();
      tick();
      checks++; if (rsp_valid !== exp_oh) begin errors++; $display("[TB] FAIL rr_rsp_valid%0d: got %b want %b", k, rsp_valid, exp_oh); end
      checks++; if (rsp_result !== exp_res) begin errors++; $display("[TB] FAIL rr_result%0d: got %h want %h", k, rsp_result, exp_res); end
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    req_valid = 2'b10; req_a1 = 32'd5; req_b1 = 32'd0; req_ctrl1 = 4'b0111;
    rsp_ready = 2'b00;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("[TB] FAIL hold_grant1: got %b want 10", req_ready); end
    tick();
    req_valid = 2'b01; req_a0 = 32'h1234; req_b0 = 32'd1; req_ctrl0 = 4'hF;
    tick();
    for (int i = 0; i < 5; i++) begin
      rsp_ready = 2'b01;
      #1;
      checks++; if (rsp_valid !== 2'b10) begin errors++; $display("[TB] FAIL hold_valid%0d: got %b want 10", i, rsp_valid); end
      checks++; if (rsp_zero !== 1'b1 || rsp_result !== 32'd0) begin errors++; $display("[TB] FAIL hold_data%0d: got %h/%b want 0/1", i, rsp_result, rsp_zero); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL hold_block%0d: got %b want 00", i, req_ready); end
      tick();
    end
    rsp_ready = 2'b10;
    #1;
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("[TB] FAIL hold_last: got %b want 10", rsp_valid); end
    tick();
    rsp_ready = 2'b00;
    #1;
    checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b01) begin errors++; $display("[TB] FAIL hold_release: rsp=%b rdy=%b want 00/01", rsp_valid, req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if (alu_ctrl !== 4'hF || alu_a !== 32'h1234) begin errors++; $display("[TB] FAIL unknown_ctrl_in: got %h/%h want F/1234", alu_ctrl, alu_a); end
    tick();
    checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'hDEADBEEF || rsp_zero !== 1'b0) begin errors++; $display("[TB] FAIL unknown_ctrl_rsp: got %b %h %b want 01 deadbeef 0", rsp_valid, rsp_result, rsp_zero); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 2'b01; req_a0 = 32'd7; req_b0 = 32'd1; req_ctrl0 = 4'b0010;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL mid_grant: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    reset = 1'b1;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL mid_exec_rsp: got %b want 00", rsp_valid); end
    tick();
    checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || alu_a !== 32'd0 || rsp_result !== 32'd0) begin errors++; $display("[TB] FAIL mid_cleared: busy=%b rsp=%b a=%h res=%h want 0/00/0/0", busy, rsp_valid, alu_a, rsp_result); end
    reset = 1'b0;
    req_valid = 2'b11; req_a1 = 32'd3; req_b1 = 32'd4; req_ctrl1 = 4'b0010;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL mid_rr_reset: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b10;
    tick();
    checks++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd8) begin errors++; $display("[TB] FAIL mid_after_rsp0: got %b/%0d want 01/8", rsp_valid, rsp_result); end
    rsp_ready = 2'b11;
    tick();
    checks++; if (req_ready !== 2'b10) begin errors++; $display("[TB] FAIL mid_grant1: got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'd7) begin errors++; $display("[TB] FAIL mid_after_rsp1: got %b/%0d want 10/7", rsp_valid, rsp_result); end
    tick();
    rsp_ready = 2'b00;
  endtask

`ifdef ALU_SHARE_PERF_EN
  task automatic test_perf();
    do_reset();
    rsp_ready = 2'b11;
    req_a0 = 32'd1; req_b0 = 32'd1; req_ctrl0 = 4'b0010;
    req_a1 = 32'd2; req_b1 = 32'd2; req_ctrl1 = 4'b0010;
    for (int r = 0; r < 2; r++) begin
      req_valid = 2'b01;
      tick();
      req_valid = 2'b10;
      tick();
      tick();
      tick();
      req_valid = 2'b00;
      tick();
      tick();
    end
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    #1;
    checks++; if (perf_grant0 !== 32'd3) begin errors++; $display("[TB] FAIL perf_grant0: got %0d want 3", perf_grant0); end
    checks++; if (perf_grant1 !== 32'd2) begin errors++; $display("[TB] FAIL perf_grant1: got %0d want 2", perf_grant1); end
    checks++; if (perf_stall !== 32'd4) begin errors++; $display("[TB] FAIL perf_stall: got %0d want 4", perf_stall); end
    rsp_ready = 2'b00;
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_reset_mid();
`ifdef ALU_SHARE_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
